// File: rtl/prince_prng_pkg.sv
// Shared definitions for the PRINCE randomness source: lane geometry,
// per-lane constants, LFSR taps, FSM encoding and the unrolled advance.
package prince_prng_pkg;

  localparam int N_LANES       = 11;
  localparam int LANE_W        = 32;
  localparam int STEPS_PER_ADV = 32;

  // Taps of x^32 + x^22 + x^2 + x + 1 expressed as bit positions of the state
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  // Element i is the constant for lane i (element 0 in the low word)
  localparam logic [N_LANES-1:0][LANE_W-1:0] LANE_C = {
    32'hC0AC29B7, 32'hBE5466CF, 32'h34E90C6C, 32'h452821E6,
    32'h38D01377, 32'h082EFA98, 32'hEC4E6C89, 32'hA4093822,
    32'h299F31D0, 32'h13198A2E, 32'h03707344
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // One advance: STEPS_PER_ADV Fibonacci shifts, feedback enters at bit 0
  function automatic logic [LANE_W-1:0] lfsr_advance(input logic [LANE_W-1:0] s);
    logic [LANE_W-1:0] v;
    v = s;
    for (int k = 0; k < STEPS_PER_ADV; k++) begin
      v = {v[LANE_W-2:0], v[TAP_A] ^ v[TAP_B] ^ v[TAP_C] ^ v[TAP_D]};
    end
    return v;
  endfunction

endpackage

// File: rtl/prince_prng_lane.sv
// One 32-bit LFSR lane: seed load with zero substitution, a fully unrolled
// 32-step advance, and (with PRINCE_PRNG_HEALTH_EN) a stuck/zero detector.
module prince_lfsr_lane
  import prince_prng_pkg::*;
#(
  parameter logic [LANE_W-1:0] LANE_CONST = 32'h00000001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              adv,
  input  logic [LANE_W-1:0] seed_word,
  output logic [LANE_W-1:0] lane,
  output logic              fault
);

  logic [LANE_W-1:0] mixed;
  logic [LANE_W-1:0] seeded;
  logic [LANE_W-1:0] stepped;

  // An all-zero state would lock the LFSR, so fall back to the lane constant
  assign mixed   = seed_word ^ LANE_CONST;
  assign seeded  = (mixed == '0) ? LANE_CONST : mixed;
  assign stepped = lfsr_advance(lane);

  // Lane state: load has priority over advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane <= '0;
    end else if (load) begin
      lane <= seeded;
    end else if (adv) begin
      lane <= stepped;
    end
  end

`ifdef PRINCE_PRNG_HEALTH_EN
  // A healthy maximal-length LFSR never maps onto itself and never reaches zero
  assign fault = (stepped == lane) || (lane == '0);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: rtl/prince_prng.sv
// Fresh-randomness source for the masked PRINCE datapath: 11 LFSR lanes,
// seeded over valid/ready, warmed up WARMUP advances, then advanced by rnd_en.
// Optional health monitor enabled by defining PRINCE_PRNG_HEALTH_EN.
module prince_prng
  import prince_prng_pkg::*;
#(
  parameter int WARMUP = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         seed_valid,
  output logic         seed_ready,
  input  logic [127:0] seed_in,
  input  logic         rnd_en,
  output logic         rnd_valid,
  output logic [287:0] prng_out,
  output logic [63:0]  mask_out,
  output logic         health_fail
);

  localparam logic [7:0] WARMUP_LAST = 8'(WARMUP - 1);

  state_t            state;
  logic [7:0]        warm_cnt;
  logic [LANE_W-1:0] lane_q [N_LANES];
  logic [N_LANES-1:0] lane_fault;
  logic              seed_take;
  logic              any_fault;
  logic              health_q;
  logic              lane_adv;

  assign seed_take = seed_valid && seed_ready;
  assign any_fault = |lane_fault;

  // Warm-up advances unconditionally; in RUN only on request and while healthy
  assign lane_adv = !seed_take &&
                    ((state == ST_WARMUP) ||
                     ((state == ST_RUN) && rnd_en && !health_q && !any_fault));

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    prince_lfsr_lane #(
      .LANE_CONST(LANE_C[i])
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seed_take),
      .adv      (lane_adv),
      .seed_word(seed_in[32*(i%4) +: 32]),
      .lane     (lane_q[i]),
      .fault    (lane_fault[i])
    );
  end

  // Control FSM with registered seed_ready / rnd_valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      warm_cnt   <= '0;
      seed_ready <= 1'b1;
      rnd_valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (seed_take) begin
            state      <= ST_WARMUP;
            warm_cnt   <= '0;
            seed_ready <= 1'b0;
          end
        end
        ST_WARMUP: begin
          warm_cnt <= warm_cnt + 8'd1;
          if (warm_cnt == WARMUP_LAST) begin
            state      <= ST_RUN;
            seed_ready <= 1'b1;
            rnd_valid  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (seed_take) begin
            state      <= ST_WARMUP;
            warm_cnt   <= '0;
            seed_ready <= 1'b0;
            rnd_valid  <= 1'b0;
          end else if (health_q || any_fault) begin
            rnd_valid <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          seed_ready <= 1'b1;
          rnd_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PRINCE_PRNG_HEALTH_EN
  // Sticky alarm: set by a fault seen in RUN, cleared only by reset or a new seed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      health_q <= 1'b0;
    end else if (seed_take) begin
      health_q <= 1'b0;
    end else if ((state == ST_RUN) && any_fault) begin
      health_q <= 1'b1;
    end
  end
`else
  assign health_q = 1'b0;
`endif

  assign health_fail = health_q;

  // Randomness is only exposed while rnd_valid is high
  always_comb begin
    prng_out = '0;
    mask_out = '0;
    if (rnd_valid) begin
      for (int i = 0; i < 9; i++) begin
        prng_out[32*i +: 32] = lane_q[i];
      end
      mask_out = {lane_q[10], lane_q[9]};
    end
  end

endmodule

// File: tb/tb_prince_prng.sv
// Scoreboard bench for prince_prng: a behavioural model predicts every
// cycle's outputs into a queue; a monitor pops and compares each cycle.
module tb_prince_prng;

  localparam int WARMUP = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         seed_valid = 1'b0;
  logic         seed_ready;
  logic [127:0] seed_in = '0;
  logic         rnd_en = 1'b0;
  logic         rnd_valid;
  logic [287:0] prng_out;
  logic [63:0]  mask_out;
  logic         health_fail;

  always #5 clk = ~clk;

  prince_prng #(.WARMUP(WARMUP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_valid (seed_valid),
    .seed_ready (seed_ready),
    .seed_in    (seed_in),
    .rnd_en     (rnd_en),
    .rnd_valid  (rnd_valid),
    .prng_out   (prng_out),
    .mask_out   (mask_out),
    .health_fail(health_fail)
  );

  typedef struct {
    logic         ready;
    logic         valid;
    logic [287:0] prng;
    logic [63:0]  mask;
    logic         hf;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  string phase = "reset";

  logic [31:0] cst [11] = '{32'h03707344, 32'h13198A2E, 32'h299F31D0, 32'hA4093822,
                            32'hEC4E6C89, 32'h082EFA98, 32'h38D01377, 32'h452821E6,
                            32'h34E90C6C, 32'hBE5466CF, 32'hC0AC29B7};

  // Model state: warm_left < 0 means no seed held, > 0 advances still to
  // go before output, 0 means producing randomness
  logic [31:0] m_lane [11];
  int          m_warm = -1;

  function automatic logic [31:0] advance(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int k = 0; k < 32; k++) v = {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    return v;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Apply one cycle of inputs (called at a falling edge), predict the result
  task automatic drive(input logic r, input logic sv, input logic [127:0] sd, input logic en);
    exp_t        e;
    logic [31:0] t;
    bit          accepting;
    rst_n = r; seed_valid = sv; seed_in = sd; rnd_en = en;
    accepting = (m_warm <= 0);
    if (!r) begin
      for (int i = 0; i < 11; i++) m_lane[i] = '0;
      m_warm = -1;
    end else if (sv && accepting) begin
      for (int i = 0; i < 11; i++) begin
        t = sd[32*(i%4) +: 32] ^ cst[i];
        m_lane[i] = (t == 32'h0) ? cst[i] : t;
      end
      m_warm = WARMUP;
    end else if (m_warm > 0) begin
      for (int i = 0; i < 11; i++) m_lane[i] = advance(m_lane[i]);
      m_warm--;
    end else if (m_warm == 0 && en) begin
      for (int i = 0; i < 11; i++) m_lane[i] = advance(m_lane[i]);
    end
    e.ready = (m_warm <= 0);
    e.valid = (m_warm == 0);
    e.prng  = '0;
    e.mask  = '0;
    e.hf    = 1'b0;
    if (e.valid) begin
      for (int i = 0; i < 9; i++) e.prng[32*i +: 32] = m_lane[i];
      e.mask = {m_lane[10], m_lane[9]};
    end
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // After a handshake, count cycles until rnd_valid appears (bounded)
  task automatic wait_valid(input int want);
    int k;
    k = 1;
    while (!rnd_valid && k <= 100) begin
      drive(1'b1, 1'($urandom_range(0, 1)), rand128(), 1'($urandom_range(0, 1)));
      k++;
    end
    checks++;
    if (k != want) begin
      errors++;
      $display("FAIL latency[%s]: rnd_valid after %0d cycles, required %0d", phase, k, want);
    end
  endtask

  task automatic run_random(input int n, input bit allow_reseed);
    bit sv;
    for (int c = 0; c < n; c++) begin
      sv = allow_reseed && ($urandom_range(0, 15) == 0);
      drive(1'b1, sv, rand128(), 1'($urandom_range(0, 1)));
    end
  endtask

  // Monitor: compare DUT outputs against the predicted record each cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({seed_ready, rnd_valid, health_fail} !== {e.ready, e.valid, e.hf} ||
            prng_out !== e.prng || mask_out !== e.mask) begin
          errors++;
          $display("FAIL outputs[%s] t=%0t: got rdy=%b vld=%b hf=%b prng=%h mask=%h; want rdy=%b vld=%b hf=%b prng=%h mask=%h",
                   phase, $time, seed_ready, rnd_valid, health_fail, prng_out, mask_out,
                   e.ready, e.valid, e.hf, e.prng, e.mask);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset held three cycles
    phase = "reset";
    repeat (3) drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);

    // Zero seed: lanes start at their constants
    phase = "zero_seed";
    drive(1'b1, 1'b1, 128'h0, 1'b0);
    wait_valid(WARMUP + 1);
    phase = "run1";
    run_random(20, 1'b0);

    // Hold for 10 cycles, then exactly one advance
    phase = "hold";
    repeat (10) drive(1'b1, 1'b0, rand128(), 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);
    repeat (3) drive(1'b1, 1'b0, '0, 1'b0);

    // Reseed collides with rnd_en; seed word 0 forces zero substitution in lane 0
    phase = "reseed_zero_sub";
    drive(1'b1, 1'b1, {rand128() >> 32, 32'h03707344}, 1'b1);
    wait_valid(WARMUP + 1);
    phase = "run2";
    run_random(15, 1'b0);

    // Reset in the middle of warm-up discards the seed
    phase = "reset_mid_warmup";
    drive(1'b1, 1'b1, rand128(), 1'b0);
    repeat (9) drive(1'b1, 1'b1, rand128(), 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    repeat (5) drive(1'b1, 1'b0, rand128(), 1'b1);
    phase = "reseed_after_reset";
    drive(1'b1, 1'b1, rand128(), 1'b1);
    wait_valid(WARMUP + 1);

    // Random traffic including occasional reseeds in any state
    phase = "random";
    for (int r = 0; r < 6; r++) begin
      run_random(60, 1'b1);
    end

    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
